// File: rtl/nn_smoothgrad_polar_dynres_if.sv
// Bus bundle for nn_smoothgrad_polar_dynres.
// Control/stimulus: EN, IN_SS, SIGN, OUT_INIT, SIGN_OUT_INIT (master -> slave).
// Channel state:    OUT, SIGN_out, RES_LEVEL, DIRECTION_CHANGE (slave -> master).
interface nn_smoothgrad_polar_dynres_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned RES_W = 3
);
  logic                 EN;
  logic [NCH-1:0]       IN_SS;
  logic [NCH-1:0]       SIGN;
  logic [NCH*N-1:0]     OUT_INIT;
  logic [NCH-1:0]       SIGN_OUT_INIT;
  logic [NCH*N-1:0]     OUT;
  logic [NCH-1:0]       SIGN_out;
  logic [NCH*RES_W-1:0] RES_LEVEL;
  logic [NCH-1:0]       DIRECTION_CHANGE;

  modport master (
    output EN, IN_SS, SIGN, OUT_INIT, SIGN_OUT_INIT,
    input  OUT, SIGN_out, RES_LEVEL, DIRECTION_CHANGE
  );

  modport slave (
    input  EN, IN_SS, SIGN, OUT_INIT, SIGN_OUT_INIT,
    output OUT, SIGN_out, RES_LEVEL, DIRECTION_CHANGE
  );
endinterface

// File: rtl/nn_smoothgrad_polar_dynres.sv
// Multi-channel sign-magnitude stochastic accumulator with dynamic resistance.
// Each channel steps its saturating magnitude once per 2^r accepted pulses in
// one direction; r grows on direction reversals and decays after RUN_LEN
// consecutive same-direction steps.
// Ports: CLK (rising edge), INIT (sync active-high load/reset),
//        bus (slave modport) carrying EN/IN_SS/SIGN/load values in and
//        OUT/SIGN_out/RES_LEVEL/DIRECTION_CHANGE (all registered) out.
module nn_smoothgrad_polar_dynres #(
  parameter int unsigned N       = 8,
  parameter int unsigned NCH     = 4,
  parameter int unsigned RES_W   = 3,
  parameter int unsigned RES_MAX = 7,
  parameter int unsigned RUN_LEN = 16
) (
  input  logic                         CLK,
  input  logic                         INIT,
  nn_smoothgrad_polar_dynres_if.slave  bus
);

  localparam int unsigned CNT_W = (RES_MAX > 0) ? RES_MAX : 1;
  localparam int unsigned RUN_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN - 1);
  localparam logic [RES_W-1:0] R_MAX    = RES_W'(RES_MAX);

  logic [NCH-1:0][N-1:0]     mag_q, mag_d;
  logic [NCH-1:0]            sgn_q, sgn_d;
  logic [NCH-1:0][RES_W-1:0] res_q, res_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][RUN_W-1:0] run_q, run_d;
  logic [NCH-1:0]            dir_q, dir_d;
  logic [NCH-1:0]            vld_q, vld_d;
  logic [NCH-1:0]            dchg_q, dchg_d;

  // Per-channel next-state: reversal, accumulate or step.
  always_comb begin
    mag_d  = mag_q;
    sgn_d  = sgn_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    dir_d  = dir_q;
    vld_d  = vld_q;
    dchg_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (bus.EN && bus.IN_SS[c]) begin
        if (vld_q[c] && (bus.SIGN[c] != dir_q[c])) begin
          dchg_d[c] = 1'b1;
          if (res_q[c] != R_MAX) res_d[c] = res_q[c] + RES_W'(1);
          cnt_d[c] = '0;
          run_d[c] = '0;
          dir_d[c] = bus.SIGN[c];
        end else if (cnt_q[c] != ~({CNT_W{1'b1}} << res_q[c])) begin
          // Threshold 2^r-1 is the low r bits set.
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end else begin
          cnt_d[c] = '0;
          dir_d[c] = bus.SIGN[c];
          vld_d[c] = 1'b1;
          if (mag_q[c] == '0) begin
            mag_d[c] = N'(1);
            sgn_d[c] = bus.SIGN[c];
          end else if (bus.SIGN[c] == sgn_q[c]) begin
            if (mag_q[c] != '1) mag_d[c] = mag_q[c] + N'(1);
          end else begin
            mag_d[c] = mag_q[c] - N'(1);
          end
          // Run counter parks at RUN_LEN-1 when r is already 0.
          if (run_q[c] == RUN_LAST) begin
            if (res_q[c] != '0) begin
              res_d[c] = res_q[c] - RES_W'(1);
              run_d[c] = '0;
            end
          end else begin
            run_d[c] = run_q[c] + RUN_W'(1);
          end
        end
      end
    end
  end

  // State registers with synchronous load.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      mag_q  <= bus.OUT_INIT;
      sgn_q  <= bus.SIGN_OUT_INIT;
      res_q  <= '0;
      cnt_q  <= '0;
      run_q  <= '0;
      dir_q  <= '0;
      vld_q  <= '0;
      dchg_q <= '0;
    end else begin
      mag_q  <= mag_d;
      sgn_q  <= sgn_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      dir_q  <= dir_d;
      vld_q  <= vld_d;
      dchg_q <= dchg_d;
    end
  end

  assign bus.OUT              = mag_q;
  assign bus.SIGN_out         = sgn_q;
  assign bus.RES_LEVEL        = res_q;
  assign bus.DIRECTION_CHANGE = dchg_q;

endmodule

// File: tb/tb_nn_smoothgrad_polar_dynres.sv
// Scoreboard bench for nn_smoothgrad_polar_dynres (N=8, NCH=4, RUN_LEN=4).
module tb_nn_smoothgrad_polar_dynres;

  logic clk = 1'b0;
  logic init_s;
  always #5 clk = ~clk;

  nn_smoothgrad_polar_dynres_if #(.N(8), .NCH(4), .RES_W(3)) bus ();

  nn_smoothgrad_polar_dynres #(
    .N(8), .NCH(4), .RES_W(3), .RES_MAX(7), .RUN_LEN(4)
  ) dut (
    .CLK  (clk),
    .INIT (init_s),
    .bus  (bus)
  );

  typedef struct {
    int       tag;
    string    name;
    int       ch;
    logic [7:0] mag;
    logic     sgn;
    logic [2:0] res;
    logic     dc;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every cycle, check all expectations tagged for the edge just taken.
  initial begin
    exp_t e;
    logic [7:0] am;
    logic [2:0] ar;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].tag < cyc_cnt) begin
        e  = sb.pop_front();
        am = bus.OUT[e.ch*8 +: 8];
        ar = bus.RES_LEVEL[e.ch*3 +: 3];
        total++;
        if (am !== e.mag || bus.SIGN_out[e.ch] !== e.sgn ||
            ar !== e.res || bus.DIRECTION_CHANGE[e.ch] !== e.dc) begin
          bad++;
          $display("FAIL %s ch%0d: got out=%0d sign=%b res=%0d dc=%b, want out=%0d sign=%b res=%0d dc=%b",
                   e.name, e.ch, am, bus.SIGN_out[e.ch], ar, bus.DIRECTION_CHANGE[e.ch],
                   e.mag, e.sgn, e.res, e.dc);
        end
      end
    end
  end

  task automatic drive(input logic en, input logic [3:0] in_ss, input logic [3:0] sign);
    @(negedge clk);
    init_s   = 1'b0;
    bus.EN   = en;
    bus.IN_SS = in_ss;
    bus.SIGN = sign;
  endtask

  task automatic load(input logic [31:0] vals, input logic [3:0] sgns);
    @(negedge clk);
    init_s            = 1'b1;
    bus.EN            = 1'b1;
    bus.IN_SS         = 4'hF;
    bus.SIGN          = 4'hF;
    bus.OUT_INIT      = vals;
    bus.SIGN_OUT_INIT = sgns;
  endtask

  task automatic expect_ch(input int ch, input int mag, input logic sgn,
                           input int res, input logic dc, input string name);
    exp_t e;
    e.tag  = cyc_cnt;
    e.name = name;
    e.ch   = ch;
    e.mag  = 8'(mag);
    e.sgn  = sgn;
    e.res  = 3'(res);
    e.dc   = dc;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    init_s            = 1'b0;
    bus.EN            = 1'b0;
    bus.IN_SS         = '0;
    bus.SIGN          = '0;
    bus.OUT_INIT      = {8'd30, 8'd20, 8'd10, 8'd5};
    bus.SIGN_OUT_INIT = 4'b0001;
    repeat (2) @(posedge clk);

    // Load with EN and pulses active: INIT wins.
    load({8'd30, 8'd20, 8'd10, 8'd5}, 4'b0001);
    expect_ch(0, 5, 1'b1, 0, 1'b0, "init_ch0");
    expect_ch(1, 10, 1'b0, 0, 1'b0, "init_ch1");
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'hF, 4'hF);
      expect_ch(0, 5, 1'b1, 0, 1'b0, "en_hold_ch0");
      expect_ch(3, 30, 1'b0, 0, 1'b0, "en_hold_ch3");
    end

    // Zero crossing at r=0.
    load({8'd30, 8'd20, 8'd10, 8'd1}, 4'b0000);
    expect_ch(0, 1, 1'b0, 0, 1'b0, "zc_load");
    drive(1'b1, 4'b0001, 4'b0001); expect_ch(0, 0, 1'b0, 0, 1'b0, "zc_p1");
    drive(1'b1, 4'b0001, 4'b0001); expect_ch(0, 1, 1'b1, 0, 1'b0, "zc_p2");
    drive(1'b1, 4'b0001, 4'b0001); expect_ch(0, 2, 1'b1, 0, 1'b0, "zc_p3");

    // Saturation.
    load({8'd30, 8'd20, 8'd10, 8'd254}, 4'b0000);
    expect_ch(0, 254, 1'b0, 0, 1'b0, "sat_load");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0001, 4'b0000);
      expect_ch(0, 255, 1'b0, 0, 1'b0, "sat");
    end

    // Resistance growth, then 2^3 pulses per step, then cap at RES_MAX.
    load({8'd30, 8'd20, 8'd10, 8'd100}, 4'b0000);
    expect_ch(0, 100, 1'b0, 0, 1'b0, "grow_load");
    drive(1'b1, 4'b0001, 4'b0000); expect_ch(0, 101, 1'b0, 0, 1'b0, "grow_step");
    drive(1'b1, 4'b0001, 4'b0001); expect_ch(0, 101, 1'b0, 1, 1'b1, "grow_rev1");
    drive(1'b1, 4'b0001, 4'b0000); expect_ch(0, 101, 1'b0, 2, 1'b1, "grow_rev2");
    drive(1'b1, 4'b0001, 4'b0001); expect_ch(0, 101, 1'b0, 3, 1'b1, "grow_rev3");
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'b0001, 4'b0001);
      expect_ch(0, 101, 1'b0, 3, 1'b0, "grow_accum");
    end
    drive(1'b1, 4'b0001, 4'b0001); expect_ch(0, 100, 1'b0, 3, 1'b0, "grow_8th");
    drive(1'b1, 4'b0001, 4'b0000); expect_ch(0, 100, 1'b0, 4, 1'b1, "cap_r4");
    drive(1'b1, 4'b0001, 4'b0001); expect_ch(0, 100, 1'b0, 5, 1'b1, "cap_r5");
    drive(1'b1, 4'b0001, 4'b0000); expect_ch(0, 100, 1'b0, 6, 1'b1, "cap_r6");
    drive(1'b1, 4'b0001, 4'b0001); expect_ch(0, 100, 1'b0, 7, 1'b1, "cap_r7");
    drive(1'b1, 4'b0001, 4'b0000); expect_ch(0, 100, 1'b0, 7, 1'b1, "cap_hold");

    // Decay: r=2, RUN_LEN=4.
    load({8'd30, 8'd20, 8'd10, 8'd50}, 4'b0000);
    expect_ch(0, 50, 1'b0, 0, 1'b0, "decay_load");
    drive(1'b1, 4'b0001, 4'b0000); expect_ch(0, 51, 1'b0, 0, 1'b0, "decay_step");
    drive(1'b1, 4'b0001, 4'b0001); expect_ch(0, 51, 1'b0, 1, 1'b1, "decay_rev1");
    drive(1'b1, 4'b0001, 4'b0000); expect_ch(0, 51, 1'b0, 2, 1'b1, "decay_rev2");
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 4'b0001, 4'b0000);
      expect_ch(0, 51 + k / 4, 1'b0, (k == 16) ? 1 : 2, 1'b0, "decay_run");
    end
    drive(1'b1, 4'b0001, 4'b0000); expect_ch(0, 55, 1'b0, 1, 1'b0, "decay_r1_a");
    drive(1'b1, 4'b0001, 4'b0000); expect_ch(0, 56, 1'b0, 1, 1'b0, "decay_r1_b");

    // Isolation on ch2, then INIT mid-accumulation.
    load({8'd30, 8'd20, 8'd10, 8'd5}, 4'b0001);
    expect_ch(2, 20, 1'b0, 0, 1'b0, "iso_load");
    drive(1'b1, 4'b0100, 4'b1011); expect_ch(2, 21, 1'b0, 0, 1'b0, "iso_step");
    drive(1'b1, 4'b0100, 4'b1111); expect_ch(2, 21, 1'b0, 1, 1'b1, "iso_rev1");
    expect_ch(0, 5, 1'b1, 0, 1'b0, "iso_ch0");
    expect_ch(1, 10, 1'b0, 0, 1'b0, "iso_ch1");
    expect_ch(3, 30, 1'b0, 0, 1'b0, "iso_ch3");
    drive(1'b1, 4'b0100, 4'b1011); expect_ch(2, 21, 1'b0, 2, 1'b1, "iso_rev2");
    expect_ch(3, 30, 1'b0, 0, 1'b0, "iso_ch3_b");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0100, 4'b0000);
      expect_ch(2, 21, 1'b0, 2, 1'b0, "iso_accum");
    end
    load({8'd30, 8'd20, 8'd10, 8'd5}, 4'b0001);
    expect_ch(2, 20, 1'b0, 0, 1'b0, "mid_init");
    drive(1'b1, 4'b0100, 4'b0100); expect_ch(2, 19, 1'b0, 0, 1'b0, "post_init_step");
    expect_ch(1, 10, 1'b0, 0, 1'b0, "post_init_ch1");

    drive(1'b0, 4'b0000, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
